// File: rtl/paddle_pkg.sv
// paddle_pkg: shared states and constants for the paddle arbiter
package paddle_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_SERVE, PLAY, SWAP, OVER} state_e;
  localparam int PADDLE_MIN = 1;
  localparam int PADDLE_RESET = 9;
  localparam int LIVES_W = 2;
endpackage

// File: rtl/paddle_slew.sv
// paddle_slew: clamps the target and updates the registered paddle position on sample strobes
// PADDLE_SLEW_EN: move at most one step per sample instead of loading the target directly
module paddle_slew
  import paddle_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int LIMIT = 19
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sample_i,
  input  logic [WIDTH-1:0] pos_i,
  output logic [WIDTH-1:0] paddle_pos_o
);
  logic [WIDTH-1:0] target, paddle_pos_d, paddle_pos_q;
  always_comb begin
    target = pos_i < WIDTH'(PADDLE_MIN) ? WIDTH'(PADDLE_MIN) :
             pos_i > WIDTH'(LIMIT) ? WIDTH'(LIMIT) : pos_i;
`ifdef PADDLE_SLEW_EN
    paddle_pos_d = target > paddle_pos_q ? paddle_pos_q + WIDTH'(1) :
                   target < paddle_pos_q ? paddle_pos_q - WIDTH'(1) : paddle_pos_q;
`else
    paddle_pos_d = target;
`endif
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) paddle_pos_q <= WIDTH'(PADDLE_RESET);
    else if (sample_i) paddle_pos_q <= paddle_pos_d;
  assign paddle_pos_o = paddle_pos_q;
endmodule

// File: rtl/paddle_arbiter.sv
// paddle_arbiter: sequences a two-player game sharing one paddle, tracking lives and serves
// PADDLE_SLEW_EN (see paddle_slew) limits paddle motion to one step per frame
module paddle_arbiter
  import paddle_pkg::*;
#(
  parameter int WIDTH       = 6,
  parameter int LIMIT       = 19,
  parameter int LIVES       = 3,
  parameter int SWAP_FRAMES = 60
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   pos0_i,
  input  logic [WIDTH-1:0]   pos1_i,
  input  logic               frame_tick_i,
  input  logic               serve_btn_i,
  input  logic               ball_lost_i,
  output logic [WIDTH-1:0]   paddle_pos_o,
  output logic               active_player_o,
  output logic               serve_go_o,
  output logic [LIVES_W-1:0] lives0_o,
  output logic [LIVES_W-1:0] lives1_o,
  output logic               game_over_o
);
  localparam int CW = $clog2(SWAP_FRAMES + 1);
  state_e state_q, state_d;
  logic serve_q, serve_edge, active_q, active_d, go_q, go_d;
  logic [LIVES_W-1:0] lives0_q, lives0_d, lives1_q, lives1_d, lives_act, lives_oth, lives_dec;
  logic [CW-1:0] swap_q, swap_d;
  assign serve_edge = serve_btn_i & ~serve_q;
  assign lives_act = active_q ? lives1_q : lives0_q;
  assign lives_oth = active_q ? lives0_q : lives1_q;
  assign lives_dec = lives_act == '0 ? '0 : lives_act - LIVES_W'(1);
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    lives0_d = lives0_q;
    lives1_d = lives1_q;
    swap_d   = swap_q;
    go_d     = 1'b0;
    case (state_q)
      IDLE: if (serve_edge) begin
        state_d  = WAIT_SERVE;
        lives0_d = LIVES_W'(LIVES);
        lives1_d = LIVES_W'(LIVES);
        active_d = 1'b0;
      end
      WAIT_SERVE: if (serve_edge) begin
        state_d = PLAY;
        go_d    = 1'b1;
      end
      PLAY: if (ball_lost_i) begin
        lives0_d = active_q ? lives0_q : lives_dec;
        lives1_d = active_q ? lives_dec : lives1_q;
        // the turn passes only to a player who still has lives
        active_d = active_q ^ (lives_oth != '0);
        swap_d   = '0;
        state_d  = (lives_dec == '0 && lives_oth == '0) ? OVER : SWAP;
      end
      SWAP: if (frame_tick_i) begin
        swap_d  = swap_q + CW'(1);
        state_d = swap_q == CW'(SWAP_FRAMES - 1) ? WAIT_SERVE : SWAP;
      end
      OVER: if (serve_edge) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q  <= IDLE;
      serve_q  <= 1'b0;
      active_q <= 1'b0;
      go_q     <= 1'b0;
      lives0_q <= '0;
      lives1_q <= '0;
      swap_q   <= '0;
    end else begin
      state_q  <= state_d;
      serve_q  <= serve_btn_i;
      active_q <= active_d;
      go_q     <= go_d;
      lives0_q <= lives0_d;
      lives1_q <= lives1_d;
      swap_q   <= swap_d;
    end
  paddle_slew #(.WIDTH(WIDTH), .LIMIT(LIMIT)) u_slew (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_i     (frame_tick_i & (state_q == WAIT_SERVE || state_q == PLAY)),
    .pos_i        (active_q ? pos1_i : pos0_i),
    .paddle_pos_o (paddle_pos_o)
  );
  assign active_player_o = active_q;
  assign serve_go_o      = go_q;
  assign lives0_o        = lives0_q;
  assign lives1_o        = lives1_q;
  assign game_over_o     = state_q == OVER;
endmodule

// File: doc/paddle_arbiter.md
Name: paddle_arbiter

Overview:
Shares the single on-screen paddle between two players' encoder position outputs. Sequences the game: idle, serve wait, play, turn swap and game over. Samples the active player's position once per video frame, clamps it, and drives the paddle position used by the game and render logic. Tracks lives per player and issues the serve strobe to the ball logic.

Parameters:
WIDTH, 6, width of encoder positions and paddle_pos
LIMIT, 19, maximum legal paddle position; minimum is fixed at 1
LIVES, 3, lives loaded per player at game start (1..3)
SWAP_FRAMES, 60, frame_tick count spent in SWAP before the next serve wait

Ports:
clk  in  1  system clock
reset_n  in  1  reset
pos0  in  WIDTH  player 0 encoder position
pos1  in  WIDTH  player 1 encoder position
frame_tick  in  1  one-cycle pulse at start of vertical blank
serve_btn  in  1  debounced, synchronous serve/start button level
ball_lost  in  1  one-cycle pulse when the ball passes the paddle
paddle_pos  out  WIDTH  registered paddle position
active_player  out  1  0 or 1: player owning the paddle
serve_go  out  1  one-cycle pulse that launches the ball
lives0  out  2  player 0 lives remaining
lives1  out  2  player 1 lives remaining
game_over  out  1  high while in OVER

Behaviour:
- Reset: asynchronous, active-low reset_n; clock clk, rising edge. All state is asynchronously reset.
- Reset values: state=IDLE, paddle_pos=9, active_player=0, serve_go=0, lives0=lives1=0, game_over=0, swap count=0, serve_btn edge register=0.
- serve_btn is used only through an internal rising-edge detect (registered previous level). Holding the button generates exactly one event.
- Target position = pos of the active player, clamped: 0 gives 1, any value >LIMIT gives LIMIT, otherwise unchanged.
- paddle_pos updates only on frame_tick cycles, in WAIT_SERVE and PLAY; the new value is visible the cycle after frame_tick. In IDLE, SWAP and OVER, paddle_pos holds.
- IDLE: serve edge loads lives0=lives1=LIVES, sets active_player=0, and moves to WAIT_SERVE.
- WAIT_SERVE: serve edge pulses serve_go for exactly one cycle, the cycle after the edge is registered, and moves to PLAY.
- PLAY on ball_lost:
  - Decrement the active player's lives. Lives never wrap below 0.
  - If both players then have 0 lives, go to OVER.
  - Otherwise, if the other player has lives >0, toggle active_player; if not, keep it.
  - Clear the swap count and go to SWAP.
- SWAP: count frame_tick pulses. On the SWAP_FRAMES-th tick, go to WAIT_SERVE.
- OVER: game_over=1. Serve edge goes to IDLE; lives hold until the next IDLE serve edge.
- ball_lost outside PLAY and serve edges in PLAY or SWAP are ignored.
- ball_lost and frame_tick in the same PLAY cycle: both take effect. paddle_pos is sampled from the pre-toggle active player, and the state moves to SWAP.
- Reset mid-game returns to IDLE immediately; no pulse is emitted.

Optional Feature:
PADDLE_SLEW_EN
- Defined: on each sampling frame_tick, paddle_pos moves at most ±1 toward the clamped target. Equal target means no change.
- Undefined: paddle_pos loads the clamped target directly.
- State machine timing is identical in both builds.

Decomposition:
- Package paddle_pkg:
  - state enum {IDLE, WAIT_SERVE, PLAY, SWAP, OVER}
  - PADDLE_MIN=1
  - PADDLE_RESET=9
  - lives width constant
- Sub-module paddle_slew:
  - clamp plus per-frame update (direct or slewed under PADDLE_SLEW_EN)
  - registered paddle_pos output, reset to 9
  - parameters WIDTH and LIMIT

Test Plan:
- Reset, serve_btn held high for 5 cycles -> IDLE to WAIT_SERVE, lives0=lives1=3, active_player=0, no serve_go. Release then press -> exactly one serve_go pulse, state PLAY.
- PLAY, pos0=0 then pos0=25, with a frame_tick after each -> paddle_pos=1 then 19 (direct build). With PADDLE_SLEW_EN from 9 toward 19 -> 10, 11, ... one step per tick.
- PLAY, pos1=4 changes while no frame_tick occurs -> paddle_pos unchanged. pos0 changes with no frame_tick -> paddle_pos unchanged.
- ball_lost in PLAY -> lives0=2, active_player=1, SWAP. After 60 frame_ticks -> WAIT_SERVE. paddle_pos follows pos1 on the next tick.
- Drive 6 ball_lost events across alternating turns -> after the last, lives0=lives1=0, game_over=1. Serve edge -> IDLE; next serve edge -> lives reload to 3.
- ball_lost coincident with frame_tick, active=0, pos0=7, pos1=12 -> paddle_pos=7, active_player=1. Reset asserted in PLAY -> all outputs at reset values within the same cycle.
